// File: rtl/down5bit_counter.sv
// Loadable down counter with a one-cycle terminal-count pulse.
// Counts toward zero, then either halts in DONE (one-shot) or reloads (periodic).
module down5bit_counter #(
   parameter int WIDTH       = 5,
   parameter int AUTO_RELOAD = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             tc,
   output logic             busy
);

   typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state;
   logic [WIDTH-1:0] reload_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out      <= '1;
         reload_q <= '1;
         state    <= RUN;
         tc       <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (load) begin
            // A zero load parks the counter immediately without a pulse.
            out      <= load_val;
            reload_q <= load_val;
            state    <= (load_val != '0) ? RUN : DONE;
         end else if (en && state == RUN) begin
            if (out > ONE) begin
               out <= out - ONE;
            end else if (out == ONE) begin
               out <= '0;
               tc  <= 1'b1;
               if (AUTO_RELOAD == 0) state <= DONE;
            end else begin
               // Only reachable when periodic: the zero cycle is followed by the reload.
               if (AUTO_RELOAD != 0) out   <= reload_q;
               else                  state <= DONE;
            end
         end
      end
   end

   assign zero = (out == '0);
   assign busy = (state == RUN);

endmodule

// File: tb/tb_down5bit_counter.sv
// Bench for down5bit_counter: one-shot and periodic instances share stimulus;
// a queue-based scoreboard compares both against an arithmetic reference model.
module tb_down5bit_counter;

   localparam int W = 5;
   localparam int EW = W + 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         load = 1'b0;
   logic         en = 1'b0;
   logic [W-1:0] load_val = '0;

   logic [W-1:0] out0, out1;
   logic         zero0, zero1, tc0, tc1, busy0, busy1;

   // ---------------- clock / reset
   always #5 clk = ~clk;

   down5bit_counter #(.WIDTH(W), .AUTO_RELOAD(0)) dut0 (
      .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
      .out(out0), .zero(zero0), .tc(tc0), .busy(busy0)
   );

   down5bit_counter #(.WIDTH(W), .AUTO_RELOAD(1)) dut1 (
      .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
      .out(out1), .zero(zero1), .tc(tc1), .busy(busy1)
   );

   // ---------------- scoreboard state
   logic [2*EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: index 0 is one-shot, index 1 is periodic.
   int m_cnt [2];
   int m_rel [2];
   bit m_done[2];
   bit m_tc  [2];

   function automatic logic [EW-1:0] pack_exp(int i);
      logic [W-1:0] c;
      c = m_cnt[i][W-1:0];
      return {c, (m_cnt[i] == 0), m_tc[i], !m_done[i]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i]  = (1 << W) - 1;
         m_rel[i]  = (1 << W) - 1;
         m_done[i] = 1'b0;
         m_tc[i]   = 1'b0;
      end
   endtask

   task automatic model_step(bit r, bit ld, int lv, bit e);
      if (r) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         m_tc[i] = 1'b0;
         if (ld) begin
            m_cnt[i]  = lv;
            m_rel[i]  = lv;
            m_done[i] = (lv == 0);
         end else if (e && !m_done[i]) begin
            if (m_cnt[i] == 0) begin
               if (i == 1) m_cnt[i] = m_rel[i];
               else        m_done[i] = 1'b1;
            end else begin
               m_cnt[i] = m_cnt[i] - 1;
               if (m_cnt[i] == 0) begin
                  m_tc[i] = 1'b1;
                  if (i == 0) m_done[i] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic compare(string name, logic [EW-1:0] act, logic [EW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t: got out=%0d zero=%b tc=%b busy=%b, want out=%0d zero=%b tc=%b busy=%b",
                  name, $time, act[EW-1:3], act[2], act[1], act[0],
                  exp[EW-1:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // ---------------- monitor: pops one expectation per negedge
   always @(negedge clk) begin : monitor
      logic [2*EW-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compare("oneshot", {out0, zero0, tc0, busy0}, e[2*EW-1:EW]);
         compare("periodic", {out1, zero1, tc1, busy1}, e[EW-1:0]);
      end
   end

   // ---------------- driver tasks
   task automatic drive(bit r, bit ld, int lv, bit e);
      @(negedge clk);
      #1;
      reset    = r;
      load     = ld;
      load_val = lv[W-1:0];
      en       = e;
      @(posedge clk);
      model_step(r, ld, lv, e);
      exp_q.push_back({pack_exp(0), pack_exp(1)});
   endtask

   task automatic run_en(int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, 1'b1);
   endtask

   // Asynchronous reset between edges, checked before any clock edge arrives.
   task automatic mid_reset(int hold);
      @(negedge clk);
      #2;
      reset = 1'b1;
      load  = 1'b0;
      en    = 1'b0;
      model_reset();
      #1;
      compare("async_rst_oneshot", {out0, zero0, tc0, busy0}, pack_exp(0));
      compare("async_rst_periodic", {out1, zero1, tc1, busy1}, pack_exp(1));
      for (int k = 0; k < hold; k++) drive(1'b1, 1'b0, 0, 1'b0);
   endtask

   // ---------------- stimulus
   initial begin
      model_reset();

      // Reset, then free count from all ones.
      drive(1'b1, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 0, 1'b0);
      run_en(5);

      // One-shot from 3, then linger in DONE.
      drive(1'b0, 1'b1, 3, 1'b0);
      run_en(14);

      // Periodic from 2: 2,1,0,2,1,0 on the periodic instance.
      drive(1'b0, 1'b1, 2, 1'b0);
      run_en(8);

      // Load wins over en; zero load goes straight to DONE.
      drive(1'b0, 1'b1, 17, 1'b0);
      drive(1'b0, 1'b1, 9, 1'b1);
      run_en(2);
      drive(1'b0, 1'b1, 0, 1'b1);
      run_en(3);

      // Enable gaps, including en low on the out = 1 cycle.
      drive(1'b0, 1'b1, 5, 1'b0);
      drive(1'b0, 1'b0, 0, 1'b1);
      drive(1'b0, 1'b0, 0, 1'b0);
      drive(1'b0, 1'b0, 0, 1'b0);
      drive(1'b0, 1'b0, 0, 1'b1);
      drive(1'b0, 1'b1, 2, 1'b0);
      drive(1'b0, 1'b0, 0, 1'b1);
      drive(1'b0, 1'b0, 0, 1'b0);
      drive(1'b0, 1'b0, 0, 1'b0);
      drive(1'b0, 1'b0, 0, 1'b1);
      run_en(2);

      // Reset mid-count at out = 12, held five cycles, then resume.
      drive(1'b0, 1'b1, 20, 1'b0);
      run_en(8);
      mid_reset(5);
      run_en(3);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         bit r, ld, e;
         int lv;
         r  = ($urandom_range(0, 63) == 0);
         ld = ($urandom_range(0, 9) == 0);
         lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31);
         e  = ($urandom_range(0, 3) != 0);
         drive(r, ld, lv, e);
      end

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
